piso_stream: RTL and testbench
==============================

# piso_stream

Parametrised parallel-in/serial-out shifter that feeds operand bits to the serial adder datapath. It accepts a WIDTH-bit word through a valid/ready load handshake, then presents one bit per transfer on a valid/enable serial port. A per-instance bit-order mode and a consumer stall input are provided. Back-to-back words stream with no idle cycle, and an optional trailing parity bit is available.

## Interface
- WIDTH, 4, parallel word width; legal range 2..32.
- LSB_FIRST, 1, 1 = bit 0 shifted out first; 0 = bit WIDTH-1 first.

- clk  input  1  rising-edge clock for all state.
- reset  input  1  synchronous, active-low reset; sampled on rising clk.
- load_valid  input  1  d_in holds a word to load.
- load_ready  output  1  block can accept a word this cycle.
- d_in  input  WIDTH  parallel word; sampled only on accept.
- shift_en  input  1  consumer takes the current bit this cycle.
- d_out  output  1  current serial bit.
- d_valid  output  1  d_out is meaningful.
- d_first  output  1  d_out is bit 0 of the frame.
- d_last  output  1  d_out is the final bit of the frame.
- busy  output  1  a frame is in progress (equals d_valid).

## Operation
- States: IDLE and SHIFT.
- Accept = load_valid & load_ready at a rising edge.
- Transfer = d_valid & shift_en at a rising edge.
- IDLE:
  - load_ready = 1, d_valid = 0, d_out = 0.
  - On accept: load the shift register with d_in, bit counter = 0, go to SHIFT.
- SHIFT:
  - d_valid = 1.
  - d_out = shreg[0] when LSB_FIRST = 1, else shreg[WIDTH-1].
  - On transfer: shift one position toward the output end, zero-fill, counter += 1.
  - No transfer: all state holds and d_out is stable (stall).
- Frame length FL = WIDTH, or WIDTH+1 with parity (see Configuration).
- d_first = d_valid & (counter == 0).
- d_last = d_valid & (counter == FL-1).
- Counter width is $clog2(FL+1) bits. It never exceeds FL-1 in SHIFT, so no wrap occurs.
- Final transfer (d_last & shift_en):
  - With a simultaneous accept, load the new word, counter = 0, stay in SHIFT.
  - Without an accept, go to IDLE.
- load_ready = (state == IDLE) | (d_last & shift_en). This is combinational from shift_en.
- Accept is ignored when load_ready = 0. The word is not latched later.
- load_valid is ignored while reset = 0. load_ready = 0 while reset = 0.

## Timing
- Reset (edge with reset = 0):
  - state IDLE, shift register 0, counter 0.
  - d_out 0, d_valid 0, d_first 0, d_last 0, busy 0.
  - load_ready is 0 while reset is low and 1 in the first cycle after reset releases.
- Reset mid-frame aborts the frame. Remaining bits are discarded and no d_last is emitted.
- Latency: accept at edge k puts the first bit on d_out, with d_valid = 1, in the cycle following edge k.
- Throughput: one bit per cycle with shift_en held high. A frame occupies exactly FL cycles.
- Streaming: a reload on the last-bit edge gives zero gap between frames.
- Stalls extend a frame by one cycle each. There is no timeout.
- All outputs are registered except load_ready, d_first and d_last. d_first and d_last decode registered state only.

## Configuration
- Macro: PISO_STREAM_PARITY_EN.
- Defined:
  - FL = WIDTH+1.
  - On accept, even parity (^d_in) is captured into a parity register.
  - Parity is driven as the final bit, after all data bits, regardless of LSB_FIRST.
  - d_last marks the parity bit.
- Undefined:
  - FL = WIDTH and no parity register exists.
  - d_last marks the last data bit.

## Test plan
- Reset, then load d_in = 4'b1011 with LSB_FIRST = 1 and shift_en = 1:
  - d_out = 1,1,0,1 in cycles 1–4.
  - d_first in cycle 1 only, d_last in cycle 4 only.
  - load_ready = 0 in cycles 1–3 and 1 in cycle 4.
  - d_valid = 0 in cycle 5.
- LSB_FIRST = 0, d_in = 4'b1011 -> d_out = 1,0,1,1.
- Stall: shift_en = 0 in cycle 2 of word 4'b1011 (LSB first):
  - d_out holds 1 in cycles 2–3.
  - Sequence completes 1,1,1,0,1 over 5 cycles.
  - d_last appears in cycle 5.
- Back-to-back (no parity): load 4'hA, then assert load_valid with 4'h5 during the d_last cycle:
  - 8 contiguous valid bits 0,1,0,1,1,0,1,0.
  - d_first asserted in cycles 1 and 5.
- Reset asserted after 2 bits of 4'hF:
  - Next cycle d_valid = 0, d_out = 0, load_ready = 0.
  - After release, loading 4'h3 yields a clean 1,1,0,0 frame.
- PISO_STREAM_PARITY_EN defined, WIDTH = 4, LSB first:
  - 4'b1011 -> 1,1,0,1,1, with d_last on bit 5.
  - 4'b1001 -> 1,0,0,1,0.

Source files
------------

// File: rtl/piso_stream.sv
// piso_stream: parallel-in/serial-out shifter feeding operand bits to the serial adder.
// Latency: a word accepted at edge k drives its first bit on d_out in cycle k+1; one bit per transfer.
// Backpressure: shift_en low stalls the frame with all state held; load_ready only rises when idle or on the last-bit transfer.
// Optional trailing even-parity bit: define PISO_STREAM_PARITY_EN.
module piso_stream #(
  parameter int WIDTH     = 4,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] d_in,
  input  logic             shift_en,
  output logic             d_out,
  output logic             d_valid,
  output logic             d_first,
  output logic             d_last,
  output logic             busy
);

`ifdef PISO_STREAM_PARITY_EN
  localparam int FL = WIDTH + 1;
`else
  localparam int FL = WIDTH;
`endif
  localparam int CW = $clog2(FL + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FL - 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]    state;
  // The parity bit, when enabled, is held in the extra shift-register
  // position at the far end so it leaves after every data bit.
  logic [FL-1:0] shreg;
  logic [CW-1:0] cnt;
  logic [FL-1:0] load_word;
  logic [FL-1:0] shift_word;
  logic          accept;
  logic          transfer;

  // Build the frame image captured on accept (data plus optional parity).
  always_comb begin
`ifdef PISO_STREAM_PARITY_EN
    load_word = LSB_FIRST ? {^d_in, d_in} : {d_in, ^d_in};
`else
    load_word = d_in;
`endif
  end

  // Next shift-register image after one transfer, zero-filled behind the output end.
  always_comb begin
    if (LSB_FIRST) shift_word = {1'b0, shreg[FL-1:1]};
    else           shift_word = {shreg[FL-2:0], 1'b0};
  end

  // Status decode; d_out is a direct flop bit and drains to 0 by the end of each frame.
  always_comb begin
    d_valid    = (state == SHIFT);
    busy       = d_valid;
    d_out      = LSB_FIRST ? shreg[0] : shreg[FL-1];
    d_first    = d_valid & (cnt == '0);
    d_last     = d_valid & (cnt == CNT_LAST);
    load_ready = reset & ((state == IDLE) | (d_last & shift_en));
    accept     = load_valid & load_ready;
    transfer   = d_valid & shift_en;
  end

  // Frame state: reload takes priority so a last-bit accept streams with no gap.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
    end else if (accept) begin
      state <= SHIFT;
      shreg <= load_word;
      cnt   <= '0;
    end else if (transfer) begin
      shreg <= shift_word;
      if (cnt == CNT_LAST) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_piso_stream.sv
// Bench for piso_stream: two instances (LSB-first and MSB-first) share stimulus,
// and both are compared each cycle against a queue-of-frame-bits reference model.
module tb_piso_stream;
  localparam int W = 4;
`ifdef PISO_STREAM_PARITY_EN
  localparam int FLT = W + 1;
`else
  localparam int FLT = W;
`endif

  logic         clk;
  logic         reset;
  logic         load_valid;
  logic [W-1:0] d_in;
  logic         shift_en;

  logic lr_l, do_l, dv_l, df_l, dl_l, bz_l;
  logic lr_m, do_m, dv_m, df_m, dl_m, bz_m;

  int checks = 0;
  int errors = 0;

  // Reference model: remaining bits of the frame in transmit order.
  bit q_l[$];
  bit q_m[$];
  int pos = 0;

  logic last_l, last_m;
  logic [W:0] gl, gm;
  logic [W:0] exp_gl, exp_gm;

  piso_stream #(.WIDTH(W), .LSB_FIRST(1'b1)) u_lsb (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(lr_l),
    .d_in(d_in), .shift_en(shift_en), .d_out(do_l), .d_valid(dv_l),
    .d_first(df_l), .d_last(dl_l), .busy(bz_l)
  );

  piso_stream #(.WIDTH(W), .LSB_FIRST(1'b0)) u_msb (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(lr_m),
    .d_in(d_in), .shift_en(shift_en), .d_out(do_m), .d_valid(dv_m),
    .d_first(df_m), .d_last(dl_m), .busy(bz_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", tag, $time, got, exp);
    end
  endtask

  task automatic load_frame(input logic [W-1:0] din);
    q_l.delete();
    q_m.delete();
    for (int i = 0; i < W; i++) begin
      q_l.push_back(din[i]);
      q_m.push_back(din[W-1-i]);
    end
`ifdef PISO_STREAM_PARITY_EN
    q_l.push_back(^din);
    q_m.push_back(^din);
`endif
  endtask

  // Drive one cycle of inputs, check every output, then advance the model at the edge.
  task automatic cycle(input logic r, input logic lv, input logic [W-1:0] din, input logic se);
    logic ev, ef, el, er, eo_l, eo_m;
    @(negedge clk);
    reset      = r;
    load_valid = lv;
    d_in       = din;
    shift_en   = se;
    #1;
    ev   = (q_l.size() > 0);
    eo_l = ev ? q_l[0] : 1'b0;
    eo_m = ev ? q_m[0] : 1'b0;
    ef   = ev && (pos == 0);
    el   = ev && (q_l.size() == 1);
    er   = r && (!ev || (el && se));
    check("lsb_valid", dv_l, ev);
    check("lsb_busy",  bz_l, ev);
    check("lsb_out",   do_l, eo_l);
    check("lsb_first", df_l, ef);
    check("lsb_last",  dl_l, el);
    check("lsb_ready", lr_l, er);
    check("msb_valid", dv_m, ev);
    check("msb_out",   do_m, eo_m);
    check("msb_first", df_m, ef);
    check("msb_last",  dl_m, el);
    check("msb_ready", lr_m, er);
    last_l = do_l;
    last_m = do_m;
    @(posedge clk);
    if (!r) begin
      q_l.delete();
      q_m.delete();
      pos = 0;
    end else begin
      if (ev && se) begin
        void'(q_l.pop_front());
        void'(q_m.pop_front());
        pos++;
      end
      if (lv && er) begin
        load_frame(din);
        pos = 0;
      end
    end
  endtask

  initial begin
    reset      = 1'b0;
    load_valid = 1'b0;
    d_in       = '0;
    shift_en   = 1'b0;
    // First reset edge brings the design out of its unknown power-up state.
    @(posedge clk);
    cycle(1'b0, 1'b0, 4'h0, 1'b0);
    cycle(1'b0, 1'b1, 4'hF, 1'b1);

    // Basic frame 1011 in both bit orders; sequence also compared against constants.
    gl = '0;
    gm = '0;
    cycle(1'b1, 1'b1, 4'b1011, 1'b1);
    for (int i = 0; i < FLT; i++) begin
      cycle(1'b1, 1'b0, 4'h0, 1'b1);
      gl[i]         = last_l;
      gm[FLT-1-i]   = last_m;
    end
    cycle(1'b1, 1'b0, 4'h0, 1'b1);
`ifdef PISO_STREAM_PARITY_EN
    exp_gl = 5'b11011;
    exp_gm = 5'b10111;
`else
    exp_gl = 5'b01011;
    exp_gm = 5'b01011;
`endif
    for (int i = 0; i <= W; i++) begin
      check("seq_lsb_1011", gl[i], exp_gl[i]);
      check("seq_msb_1011", gm[i], exp_gm[i]);
    end

    // Stall in the second bit cycle.
    cycle(1'b1, 1'b1, 4'b1011, 1'b1);
    cycle(1'b1, 1'b0, 4'h0, 1'b1);
    cycle(1'b1, 1'b0, 4'h0, 1'b0);
    for (int i = 0; i < FLT + 1; i++) cycle(1'b1, 1'b0, 4'h0, 1'b1);

    // Back-to-back: A then 5 accepted on the last-bit cycle.
    cycle(1'b1, 1'b1, 4'hA, 1'b1);
    for (int i = 0; i < FLT - 1; i++) cycle(1'b1, 1'b0, 4'h0, 1'b1);
    cycle(1'b1, 1'b1, 4'h5, 1'b1);
    for (int i = 0; i < FLT; i++) cycle(1'b1, 1'b0, 4'h0, 1'b1);
    cycle(1'b1, 1'b0, 4'h0, 1'b1);

    // Reset after two bits of F, then a clean frame of 3.
    cycle(1'b1, 1'b1, 4'hF, 1'b1);
    cycle(1'b1, 1'b0, 4'h0, 1'b1);
    cycle(1'b1, 1'b0, 4'h0, 1'b1);
    cycle(1'b0, 1'b0, 4'h0, 1'b1);
    cycle(1'b0, 1'b1, 4'h7, 1'b1);
    cycle(1'b1, 1'b1, 4'h3, 1'b1);
    for (int i = 0; i < FLT; i++) cycle(1'b1, 1'b0, 4'h0, 1'b1);

    // Parity-relevant word 1001 and its neighbours.
    cycle(1'b1, 1'b1, 4'b1001, 1'b1);
    for (int i = 0; i < FLT; i++) cycle(1'b1, 1'b0, 4'h0, 1'b1);

    // Randomized traffic: occasional resets, bursty loads and stalls.
    repeat (3000) begin
      logic r, lv, se;
      logic [W-1:0] din;
      r   = ($urandom_range(0, 59) != 0);
      lv  = ($urandom_range(0, 2) != 0);
      se  = ($urandom_range(0, 3) != 0);
      din = W'($urandom);
      cycle(r, lv, din, se);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
